// File: rtl/holo_pkg.sv
// Shared types and constants for the phase frame loading path.
package holo_pkg;

   typedef logic [7:0] phase_t;

   typedef enum logic [1:0] {
      IDLE,
      PAYLOAD,
      CHECK,
      PEND
   } loader_state_t;

   localparam phase_t SOF_DEFAULT = 8'hA5;

endpackage

// File: rtl/phase_bank.sv
// Double-buffered phase registers: frames land in the shadow bank, and a commit
// copies every channel into the active bank on the same edge.
module phase_bank
   import holo_pkg::*;
#(
   parameter int unsigned NUM_CHANNELS = 128,
   parameter int unsigned IDX_W        = 7
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             wr_en,
   input  logic [IDX_W-1:0] wr_idx,
   input  logic [7:0]       wr_data,
   input  logic             commit,
   output logic [7:0]       active [0:NUM_CHANNELS-1]
);

   phase_t shadow_q [0:NUM_CHANNELS-1];
   phase_t active_q [0:NUM_CHANNELS-1];

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int unsigned i = 0; i < NUM_CHANNELS; i++) begin
            shadow_q[i] <= '0;
            active_q[i] <= '0;
         end
      end else begin
         if (wr_en) begin
            shadow_q[wr_idx] <= wr_data;
         end
         if (commit) begin
            for (int unsigned i = 0; i < NUM_CHANNELS; i++) begin
               active_q[i] <= shadow_q[i];
            end
         end
      end
   end

   always_comb begin
      for (int unsigned i = 0; i < NUM_CHANNELS; i++) begin
         active[i] = active_q[i];
      end
   end

endmodule

// File: rtl/phase_frame_loader.sv
// Frame parser and commit scheduler: SOF, NUM_CHANNELS phase bytes and an XOR
// checksum; a verified frame is committed to all channels on the next period boundary.
module phase_frame_loader
   import holo_pkg::*;
#(
   parameter int unsigned NUM_CHANNELS   = 128,
   parameter logic [7:0]  SOF_BYTE       = SOF_DEFAULT,
   parameter int unsigned TIMEOUT_CYCLES = 50000
) (
   input  logic       sys_clk,
   input  logic       rst_n,
   input  logic [7:0] rx_data,
   input  logic       rx_valid,
   output logic       rx_ready,
   input  logic       period_start,
   input  logic       clr_error,
   output logic [7:0] phases [0:NUM_CHANNELS-1],
   output logic       frame_ok,
   output logic       read_error,
   output logic       busy
);

   localparam int unsigned IDX_W = (NUM_CHANNELS > 1) ? $clog2(NUM_CHANNELS) : 1;
   localparam int unsigned TMO_W = $clog2(TIMEOUT_CYCLES + 1);
   localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_CHANNELS - 1);
   localparam logic [TMO_W-1:0] TMO_LAST = TMO_W'(TIMEOUT_CYCLES - 1);

   loader_state_t    state_q;
   logic [IDX_W-1:0] idx_q;
   phase_t           chk_q;
   logic [TMO_W-1:0] tmo_q;
   logic             frame_ok_q;
   logic             read_error_q;
   logic             read_error_d;

   logic xfer;
   logic in_frame;
   logic tmo_hit;
   logic chk_bad;
   logic wr_en;
   logic commit;

   assign rx_ready = (state_q != PEND);
   assign xfer     = rx_valid & rx_ready;
   assign in_frame = (state_q == PAYLOAD) || (state_q == CHECK);
   // Fires on the idle cycle that would bring the counter to TIMEOUT_CYCLES.
   assign tmo_hit  = in_frame & ~xfer & (tmo_q == TMO_LAST);
   assign chk_bad  = (state_q == CHECK) & xfer & (rx_data != chk_q);
   assign wr_en    = (state_q == PAYLOAD) & xfer;
   assign commit   = (state_q == PEND) & period_start;

   always_comb begin
      read_error_d = read_error_q;
      if (clr_error) begin
         read_error_d = 1'b0;
      end
      if (tmo_hit || chk_bad) begin
         read_error_d = 1'b1;
      end
   end

   always_ff @(posedge sys_clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q      <= IDLE;
         idx_q        <= '0;
         chk_q        <= '0;
         tmo_q        <= '0;
         frame_ok_q   <= 1'b0;
         read_error_q <= 1'b0;
      end else begin
         frame_ok_q   <= 1'b0;
         read_error_q <= read_error_d;

         if (in_frame) begin
            tmo_q <= xfer ? '0 : tmo_q + 1'b1;
         end else begin
            tmo_q <= '0;
         end

         case (state_q)
            IDLE: begin
               if (xfer && (rx_data == SOF_BYTE)) begin
                  state_q <= PAYLOAD;
                  idx_q   <= '0;
                  chk_q   <= '0;
               end
            end
            PAYLOAD: begin
               if (tmo_hit) begin
                  state_q <= IDLE;
               end else if (xfer) begin
                  chk_q <= chk_q ^ rx_data;
                  idx_q <= idx_q + 1'b1;
                  if (idx_q == LAST_IDX) begin
                     state_q <= CHECK;
                  end
               end
            end
            CHECK: begin
               if (tmo_hit) begin
                  state_q <= IDLE;
               end else if (xfer) begin
                  state_q <= chk_bad ? IDLE : PEND;
               end
            end
            PEND: begin
               if (period_start) begin
                  state_q    <= IDLE;
                  frame_ok_q <= 1'b1;
               end
            end
            default: state_q <= IDLE;
         endcase
      end
   end

   assign frame_ok   = frame_ok_q;
   assign read_error = read_error_q;
   assign busy       = (state_q != IDLE);

   phase_bank #(
      .NUM_CHANNELS (NUM_CHANNELS),
      .IDX_W        (IDX_W)
   ) u_bank (
      .clk     (sys_clk),
      .rst_n   (rst_n),
      .wr_en   (wr_en),
      .wr_idx  (idx_q),
      .wr_data (rx_data),
      .commit  (commit),
      .active  (phases)
   );

endmodule
